mdu_iterative: RTL
==================

# mdu_iterative

Parametrised iterative multiply/divide unit with HI/LO result registers. It executes signed/unsigned multiply and divide over WIDTH-bit operands, one bit per cycle, behind a start/busy handshake. It also services direct HI/LO writes. It sits in the EX stage beside the combinational ALU. The pipeline stalls any HI/LO-dependent instruction while `busy` is high and uses `cancel` to abort on exception flush.

## Interface
Parameters:
- WIDTH, 32: operand and HI/LO width; any even value ≥ 4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  launch request; sampled on a rising edge, honoured only when idle.
- op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 11x reserved (treated as no-op).
- A  in  WIDTH  operand rs (multiplicand/dividend; source for mthi/mtlo).
- B  in  WIDTH  operand rt (multiplier/divisor).
- cancel  in  1  aborts the operation in flight; HI/LO are left unchanged.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse after HI/LO are updated by mult/div.
- HI  out  WIDTH  HI register (product high half / remainder).
- LO  out  WIDTH  LO register (product low half / quotient).

## Operation
- State machine: IDLE → RUN → FIX → IDLE. A 6-bit-or-wider counter indexes RUN iterations 0..WIDTH-1.
- IDLE, start=1, op=mthi/mtlo: HI (resp. LO) ← A on that edge. No busy, no done.
- IDLE, start=1, op=mult/multu/div/divu:
  - Latch |A|, |B| (signed ops) or A, B (unsigned ops).
  - Latch result sign flags: product sign = A[W-1]^B[W-1]; quotient sign likewise; remainder sign = A[W-1]. Both are forced to 0 for unsigned ops.
  - Latch a divide-by-zero flag (B==0, divide ops only).
  - Go to RUN.
- RUN, multiply: shift-add, one multiplier bit per cycle into a 2·WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- After WIDTH iterations → FIX. FIX applies two's-complement negation per the sign flags and writes HI/LO, then → IDLE.
- Divide by zero: RUN/FIX timing is unchanged; HI/LO are not written; done still pulses.
- Signed div of MIN by -1: LO = MIN (wrap), HI = 0. No overflow flag.
- start while busy: ignored. The in-flight op is unaffected. mthi/mtlo while busy are also ignored.
- cancel:
  - In RUN or FIX: → IDLE on that edge, HI/LO unchanged, no done.
  - In IDLE, cancel has priority over start, so a simultaneous start is dropped.
- Reserved op with start: no state change.
- Reset (any time, including mid-operation): state IDLE, counter 0, HI=0, LO=0, busy=0, done=0, internal operand/accumulator registers 0.

## Timing
- Latency: start sampled at edge E0. busy=1 from just after E0 until just after E(WIDTH+1), i.e. exactly WIDTH+1 cycles.
- HI/LO are written on edge E(WIDTH+1). done=1 for the single cycle following E(WIDTH+1).
- A new start is accepted on edge E(WIDTH+1)+1 at the earliest, which gives back-to-back throughput of one op per WIDTH+2 cycles.
- busy is registered and decoded from state (RUN or FIX); it does not assert combinationally from start.
- mthi/mtlo: HI/LO are visible the cycle after the write edge.
- A/B/op need only be valid on the start edge; they may change freely afterwards.

## Test plan
- Reset mid-RUN (cycle 10 of a mult) → immediately busy=0, HI=0, LO=0; next start behaves normally.
- WIDTH=32, mult A=-3 (0xFFFFFFFD), B=5 → busy for 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; done one cycle.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE. div A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=0 after mthi 0x12345678 and mtlo 0x9ABCDEF0 → busy 33 cycles, done pulses, HI/LO still 0x12345678 / 0x9ABCDEF0.
- start multu while busy (new operands) → ignored; original div result lands unchanged at the original edge. cancel at RUN cycle 5 → busy drops next cycle, no done, HI/LO retain prior values.
- WIDTH=8, div A=0x80, B=0xFF → LO=0x80, HI=0x00, busy 9 cycles; simultaneous start+cancel in IDLE → no operation starts.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Processes one bit per cycle: shift-add multiply and restoring divide behind a start/busy handshake.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = ($clog2(WIDTH) + 1 > 6) ? $clog2(WIDTH) + 1 : 6;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;    // multiplicand (mult) or divisor (div)
    logic [2*WIDTH-1:0] acc;     // {product high, multiplier} or {unused, dividend/quotient}
    logic [WIDTH-1:0]   rem;
    logic               is_div;
    logic               psign;
    logic               rsign;
    logic               div0;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign signed_op = ~op[0];

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
        b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {rem, acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        // Trial remainder is below twice the divisor, so bit WIDTH is the borrow.
        div_ge    = ~div_diff[WIDTH];
        prod_fix  = psign ? -acc : acc;
        quo_fix   = psign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = rsign ? -rem : rem;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            rem    <= '0;
            is_div <= 1'b0;
            psign  <= 1'b0;
            rsign  <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div <= op[1];
                                psign  <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                                rsign  <= signed_op & A[WIDTH-1];
                                div0   <= op[1] & (B == '0);
                                if (op[1]) begin
                                    opnd <= b_mag;
                                    acc  <= {{WIDTH{1'b0}}, a_mag};
                                end else begin
                                    opnd <= a_mag;
                                    acc  <= {{WIDTH{1'b0}}, b_mag};
                                end
                                rem   <= '0;
                                cnt   <= '0;
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cancel) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
                            rem <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= FIX;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (!div0) begin
                            if (is_div) begin
                                HI <= rem_fix;
                                LO <= quo_fix;
                            end else begin
                                {HI, LO} <= prod_fix;
                            end
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
